led_arbiter: RTL and testbench

- Shares the board's 4-bit LED bank between NREQ requesters, e.g. the blinky divider and the SoC GPIO.
- Round-robin arbitration with a fixed time quantum, so a chatty requester cannot starve the others.
- Sits between LED sources and the top-level led pins, in the BUFGCTRL-driven clk domain.

---
 rtl/led_arb_pkg.sv | 40 ++++
 rtl/led_arbiter_if.sv | 28 ++
 rtl/led_pwm.sv | 28 ++
 rtl/led_arbiter.sv | 114 +++++++++++
 tb/tb_led_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_arb_pkg.sv
// led_arbiter shared types: FSM states, round-robin pick, PWM width.
// Optional build macro: LED_PWM_EN (adds brightness gating).
package led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } state_t;

  localparam int PWM_W  = 8;
  localparam int MAXREQ = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_t;

  // First set req[(last+k) % nreq], k=1..nreq; wrap by one subtraction
  // so no index ever leaves the nreq range.
  function automatic rr_t rr_next(
    input logic [MAXREQ-1:0] req,
    input logic [2:0]        last,
    input int                nreq
  );
    rr_t        r;
    logic [3:0] s;
    r = '0;
    for (int k = 1; k <= MAXREQ; k++) begin
      s = {1'b0, last} + 4'(k);
      if (s >= 4'(nreq)) s = s - 4'(nreq);
      if (k <= nreq && !r.valid && req[s[2:0]]) begin
        r.valid = 1'b1;
        r.idx   = s[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/led_arbiter_if.sv
// LED bank sharing bus: requests and patterns in, grant/led/busy out.
// Optional build macro: LED_PWM_EN (no effect on this interface).
interface led_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int LED_W = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*LED_W-1:0] req_led;
  logic [NREQ-1:0]       grant;
  logic [LED_W-1:0]      led;
  logic                  busy;

  modport master (
    output req,
    output req_led,
    input  grant,
    input  led,
    input  busy
  );

  modport slave (
    input  req,
    input  req_led,
    output grant,
    output led,
    output busy
  );
endinterface

// File: rtl/led_pwm.sv
// Global brightness: free-running counter gates the owner pattern.
// Only instantiated when LED_PWM_EN is defined.
module led_pwm
  import led_arb_pkg::*;
#(
  parameter int LED_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [PWM_W-1:0] duty,
  input  logic [LED_W-1:0] pat,
  output logic [LED_W-1:0] led
);

  logic [PWM_W-1:0] pwm;

  // Counter wraps every 256 cycles; pattern shown while pwm < duty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm <= '0;
      led <= '0;
    end else begin
      pwm <= pwm + 1'b1;
      led <= (pwm < duty) ? pat : '0;
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin, time-sliced owner of the LED bank with a 1-cycle gap.
// Optional build macro: LED_PWM_EN (duty port, led latency becomes 2).
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int LED_W   = 4,
  parameter int QUANTUM = 4194304,
  parameter int QW      = $clog2(QUANTUM)
) (
  input logic             clk,
  input logic             resetn,
`ifdef LED_PWM_EN
  input logic [PWM_W-1:0] duty,
`endif
  led_arbiter_if.slave    bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QUANTUM - 1);

  state_t            state;
  logic [NREQ-1:0]   grant_q;
  logic [LED_W-1:0]  led_q;
  logic              busy_q;
  logic [QW-1:0]     qcnt;
  logic [IW-1:0]     owner;

  logic [MAXREQ-1:0] req_x;
  rr_t               sel;
  logic [IW-1:0]     sel_idx;
  logic              qexp;
  logic              others;
  logic              drop;
  logic              unused_sel;

  // Widen req to the package function's fixed width.
  always_comb begin
    req_x            = '0;
    req_x[NREQ-1:0]  = bus.req;
  end

  assign sel        = rr_next(req_x, 3'(owner), NREQ);
  assign sel_idx    = sel.idx[IW-1:0];
  assign unused_sel = ^sel.idx;
  assign qexp       = (qcnt == QMAX);
  assign others     = |(bus.req & ~grant_q);
  assign drop       = !bus.req[owner];

  // Owner FSM; owner doubles as the round-robin "last" pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      grant_q <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      qcnt    <= '0;
      owner   <= IW'(NREQ - 1);
    end else begin
      unique case (state)
        IDLE, GAP: begin
          led_q <= '0;
          qcnt  <= '0;
          if (sel.valid) begin
            state   <= OWN;
            grant_q <= NREQ'(1) << sel_idx;
            owner   <= sel_idx;
            busy_q  <= 1'b1;
          end else begin
            state   <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        OWN: begin
          if (drop || (qexp && others)) begin
            state   <= GAP;
            grant_q <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            qcnt    <= '0;
          end else begin
            led_q <= bus.req_led[owner*LED_W +: LED_W];
            qcnt  <= qexp ? '0 : qcnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          led_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;

`ifdef LED_PWM_EN
  led_pwm #(
    .LED_W(LED_W)
  ) u_pwm (
    .clk   (clk),
    .resetn(resetn),
    .duty  (duty),
    .pat   (led_q),
    .led   (bus.led)
  );
`else
  assign bus.led = led_q;
`endif

endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter (NREQ=2, QUANTUM=8, LED_W=4).
// Build with LED_PWM_EN to exercise brightness gating instead.
module tb_led_arbiter;

  localparam int NREQ    = 2;
  localparam int LED_W   = 4;
  localparam int QUANTUM = 8;

  logic clk    = 1'b0;
  logic resetn = 1'b1;

  always #5 clk = ~clk;

  led_arbiter_if #(.NREQ(NREQ), .LED_W(LED_W)) bus ();

`ifdef LED_PWM_EN
  logic [7:0] duty;
`endif

  led_arbiter #(
    .NREQ   (NREQ),
    .LED_W  (LED_W),
    .QUANTUM(QUANTUM)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
`ifdef LED_PWM_EN
    .duty  (duty),
`endif
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];
  int   cnt_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [6:0] obs();
    return {bus.grant, bus.led, bus.busy};
  endfunction

  function automatic void push(string n, logic [1:0] g,
                               logic [3:0] l, logic b);
    exp_t e;
    e.name = n;
    e.v    = {g, l, b};
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    n_checks++;
    if (!$onehot0(bus.grant)) begin
      n_fail++;
      $display("FAIL onehot0 grant=%b", bus.grant);
    end
  end

  task automatic apply_reset();
    resetn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    bus.req     = 2'b11;
    bus.req_led = {4'h6, 4'h9};
    resetn      = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs() !== 7'h00) begin
        n_fail++;
        $display("FAIL reset_hold got %h want 00", obs());
      end
    end
    resetn = 1'b1;
    push("reset_first_grant", 2'b01, 4'h0, 1'b1);
    while (sb.size() != 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_fail++;
        $display("FAIL %s got %h want %h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    bus.req = 2'b00;
    apply_reset();
    bus.req     = 2'b01;
    bus.req_led = {4'h6, 4'hA};
    push("single_grant", 2'b01, 4'h0, 1'b1);
    push("single_led_a", 2'b01, 4'hA, 1'b1);
    while (sb.size() != 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_fail++;
        $display("FAIL %s got %h want %h", e.name, obs(), e.v);
      end
    end
    bus.req_led[3:0] = 4'h5;
    repeat (20) push("single_hold_5", 2'b01, 4'h5, 1'b1);
    while (sb.size() != 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_fail++;
        $display("FAIL %s got %h want %h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_preempt();
    exp_t e;
    bus.req = 2'b00;
    apply_reset();
    bus.req     = 2'b11;
    bus.req_led = {4'h6, 4'h9};
    for (int r = 0; r < 2; r++) begin
      push("pre_own0_first", 2'b01, 4'h0, 1'b1);
      repeat (QUANTUM - 1) push("pre_own0", 2'b01, 4'h9, 1'b1);
      push("pre_gap0", 2'b00, 4'h0, 1'b0);
      push("pre_own1_first", 2'b10, 4'h0, 1'b1);
      repeat (QUANTUM - 1) push("pre_own1", 2'b10, 4'h6, 1'b1);
      push("pre_gap1", 2'b00, 4'h0, 1'b0);
    end
    push("pre_back0", 2'b01, 4'h0, 1'b1);
    while (sb.size() != 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_fail++;
        $display("FAIL %s got %h want %h", e.name, obs(), e.v);
      end
    end
  endtask

  task automatic test_release();
    exp_t e;
    bus.req = 2'b00;
    apply_reset();
    bus.req     = 2'b11;
    bus.req_led = {4'h6, 4'h9};
    push("rel_c1", 2'b01, 4'h0, 1'b1);
    push("rel_c2", 2'b01, 4'h9, 1'b1);
    push("rel_c3", 2'b01, 4'h9, 1'b1);
    for (int ph = 0; ph < 3; ph++) begin
      if (ph == 1) begin
        bus.req = 2'b10;
        push("rel_gap", 2'b00, 4'h0, 1'b0);
        push("rel_new1", 2'b10, 4'h0, 1'b1);
        push("rel_new1_led", 2'b10, 4'h6, 1'b1);
      end
      if (ph == 2) begin
        bus.req = 2'b00;
        push("rel_gap2", 2'b00, 4'h0, 1'b0);
        push("rel_idle", 2'b00, 4'h0, 1'b0);
        push("rel_idle2", 2'b00, 4'h0, 1'b0);
      end
      while (sb.size() != 0) begin
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (obs() !== e.v) begin
          n_fail++;
          $display("FAIL %s got %h want %h", e.name, obs(), e.v);
        end
      end
    end
  endtask

  task automatic test_midreset();
    exp_t e;
    bus.req = 2'b00;
    apply_reset();
    bus.req     = 2'b01;
    bus.req_led = {4'h6, 4'h9};
    push("mid_grant", 2'b01, 4'h0, 1'b1);
    push("mid_led", 2'b01, 4'h9, 1'b1);
    while (sb.size() != 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_fail++;
        $display("FAIL %s got %h want %h", e.name, obs(), e.v);
      end
    end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 7'h00) begin
      n_fail++;
      $display("FAIL mid_async got %h want 00", obs());
    end
    @(posedge clk); #1;
    n_checks++;
    if (obs() !== 7'h00) begin
      n_fail++;
      $display("FAIL mid_hold got %h want 00", obs());
    end
    resetn  = 1'b1;
    bus.req = 2'b10;
    push("mid_restart", 2'b10, 4'h0, 1'b1);
    push("mid_restart_led", 2'b10, 4'h6, 1'b1);
    while (sb.size() != 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e.v) begin
        n_fail++;
        $display("FAIL %s got %h want %h", e.name, obs(), e.v);
      end
    end
  endtask

`ifdef LED_PWM_EN
  task automatic test_pwm();
    int hits;
    int odd;
    int want;
    bus.req     = 2'b00;
    bus.req_led = {4'h0, 4'hF};
    duty        = 8'd64;
    apply_reset();
    bus.req = 2'b01;
    for (int d = 0; d < 3; d++) begin
      if (d == 0) duty = 8'd64;
      if (d == 1) duty = 8'd0;
      if (d == 2) duty = 8'd255;
      cnt_q.push_back(int'(duty));
      repeat (4) begin @(posedge clk); #1; end
      hits = 0;
      odd  = 0;
      for (int i = 0; i < 256; i++) begin
        @(posedge clk); #1;
        if (bus.led == 4'hF) hits++;
        else if (bus.led != 4'h0) odd++;
      end
      want = cnt_q.pop_front();
      n_checks++;
      if (hits !== want || odd !== 0) begin
        n_fail++;
        $display("FAIL pwm_duty got %0d lit (%0d odd) want %0d",
                 hits, odd, want);
      end
    end
  endtask
`endif

  initial begin
    bus.req     = 2'b00;
    bus.req_led = '0;
`ifdef LED_PWM_EN
    duty = 8'd0;
`endif
    test_reset();
`ifdef LED_PWM_EN
    test_pwm();
`else
    test_single();
    test_preempt();
    test_release();
    test_midreset();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
